// File: rtl/flow_unpacker_if.sv
// flow_unpacker_if: buffer pop port and serial sub-word output port of the flow unpacker.
interface flow_unpacker_if #(
  parameter int WIDTH_IN  = 32,
  parameter int WIDTH_OUT = 8
);
  logic                 read_full;
  logic [WIDTH_IN-1:0]  read_data;
  logic                 read_delete;
  logic                 out_enable;
  logic                 out_strobe;
  logic [WIDTH_OUT-1:0] out_data;
  logic                 out_first;
  logic                 out_last;
  modport master (
    input  read_full, read_data, out_enable,
    output read_delete, out_strobe, out_data, out_first, out_last
  );
  modport slave (
    output read_full, read_data, out_enable,
    input  read_delete, out_strobe, out_data, out_first, out_last
  );
endinterface

// File: rtl/flow_unpacker.sv
// flow_unpacker: pops wide buffer entries and emits them as WIDTH_OUT sub-words, one per enabled cycle.
module flow_unpacker #(
  parameter int WIDTH_IN  = 32,
  parameter int WIDTH_OUT = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  flow_unpacker_if.master  fu
);
  localparam int N  = WIDTH_IN / WIDTH_OUT;
  localparam int CW = $clog2(N);
  typedef enum logic {EMPTY, LOADED} state_t;
  state_t                        state_q, state_d;
  logic [N-1:0][WIDTH_OUT-1:0]   hold_q, hold_d;
  logic [CW-1:0]                 count_q, count_d, idx;
  logic [WIDTH_OUT-1:0]          data_q, data_d;
  logic                          strobe_q, strobe_d, first_q, first_d, last_q, last_d;
  logic                          end_w, del;
  assign end_w = count_q == CW'(N - 1);
  assign idx   = (MSB_FIRST != 0) ? CW'(N - 1) - count_q : count_q;
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    count_d  = count_q;
    data_d   = data_q;
    strobe_d = 1'b0;
    first_d  = 1'b0;
    last_d   = 1'b0;
    del      = 1'b0;
    if (state_q == EMPTY) begin
      del = fu.read_full;
    end else if (fu.out_enable) begin
      strobe_d = 1'b1;
      data_d   = hold_q[idx];
      first_d  = count_q == '0;
      last_d   = end_w;
      count_d  = end_w ? '0 : count_q + CW'(1);
      del      = end_w & fu.read_full;
      state_d  = (end_w & ~fu.read_full) ? EMPTY : LOADED;
    end
    // a pop always refills the holding register, whether from EMPTY or on the last sub-word
    if (del) begin
      hold_d  = fu.read_data;
      count_d = '0;
      state_d = LOADED;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      count_q  <= '0;
      data_q   <= '0;
      strobe_q <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      first_q  <= first_d;
      last_q   <= last_d;
    end
  end
  always_ff @(posedge clk) hold_q <= hold_d;
  assign fu.read_delete = del;
  assign fu.out_strobe  = strobe_q;
  assign fu.out_data    = data_q;
  assign fu.out_first   = first_q;
  assign fu.out_last    = last_q;
endmodule
